// File: rtl/exp5_unidade_controle.sv
// Moore control unit sequencing the memory-game datapath (play, compare, advance, end flags).
// Optional per-play timeout in espera_jogada enabled by defining TIMEOUT_EN.
module exp5_unidade_controle #(
  parameter int TIMEOUT_CYCLES = 3000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       fim_contagem,
  output logic       zera_contador,
  output logic       conta_contador,
  output logic       zera_registrador,
  output logic       registra,
  output logic       acertou,
  output logic       errou,
  output logic       pronto,
  output logic       timeout,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL     = 4'b0000,
    PREPARACAO  = 4'b0001,
    ESPERA      = 4'b0010,
    REGISTRA    = 4'b0100,
    COMPARACAO  = 4'b0101,
    PROXIMO     = 4'b0110,
    FIM_ACERTOU = 4'b1010,
    FIM_ERROU   = 4'b1110,
    FIM_TIMEOUT = 4'b1101
  } state_t;

  state_t state, next;
  logic   expirou;

`ifdef TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] cnt;

  // Held at zero outside espera_jogada, so every entry starts a fresh count.
  always_ff @(posedge clock) begin
    if (reset || state != ESPERA) cnt <= '0;
    else                          cnt <= cnt + CW'(1);
  end

  assign expirou = (cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign expirou = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) state <= INICIAL;
    else       state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      INICIAL:     if (iniciar) next = PREPARACAO;
      PREPARACAO:  next = ESPERA;
      ESPERA: begin
        if (jogada)       next = REGISTRA;
        else if (expirou) next = FIM_TIMEOUT;
      end
      REGISTRA:    next = COMPARACAO;
      COMPARACAO: begin
        if (!igual)            next = FIM_ERROU;
        else if (fim_contagem) next = FIM_ACERTOU;
        else                   next = PROXIMO;
      end
      PROXIMO:     next = ESPERA;
      FIM_ACERTOU, FIM_ERROU, FIM_TIMEOUT:
                   if (iniciar) next = PREPARACAO;
      default:     next = INICIAL;
    endcase
  end

  always_comb begin
    zera_contador    = 1'b0;
    conta_contador   = 1'b0;
    zera_registrador = 1'b0;
    registra         = 1'b0;
    acertou          = 1'b0;
    errou            = 1'b0;
    pronto           = 1'b0;
    timeout          = 1'b0;
    db_estado        = state;
    case (state)
      PREPARACAO: begin
        zera_contador    = 1'b1;
        zera_registrador = 1'b1;
      end
      REGISTRA:    registra       = 1'b1;
      PROXIMO:     conta_contador = 1'b1;
      FIM_ACERTOU: begin
        pronto  = 1'b1;
        acertou = 1'b1;
      end
      FIM_ERROU: begin
        pronto = 1'b1;
        errou  = 1'b1;
      end
      FIM_TIMEOUT: begin
        pronto = 1'b1;
        errou  = 1'b1;
`ifdef TIMEOUT_EN
        timeout = 1'b1;
`endif
      end
      INICIAL, ESPERA, COMPARACAO: ;
      default: db_estado = 4'b0000;
    endcase
  end

endmodule
